// File: rtl/arb_4_rr_lock_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter with grant locking.
// Holds the FSM state type, requester count, rotation mask and one-hot decode.
package arb_4_rr_lock_pkg;

   localparam int NUM_REQ = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } state_t;

   // Requesters strictly above the last winner get first pick on the next round.
   function automatic logic [NUM_REQ-1:0] mask_above(input logic [1:0] ptr);
      logic [NUM_REQ-1:0] mask;
      case (ptr)
         2'd0:    mask = 4'b1110;
         2'd1:    mask = 4'b1100;
         2'd2:    mask = 4'b1000;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

   function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
      return {oh[3] | oh[2], oh[3] | oh[1]};
   endfunction

endpackage

// File: rtl/arb_4_lsb_pick.sv
// Combinational lowest-set-bit picker: returns a one-hot vector of the lowest set bit,
// or zero when the input is zero.
module arb_4_lsb_pick
   import arb_4_rr_lock_pkg::*;
(
   input  logic [NUM_REQ-1:0] vec,
   output logic [NUM_REQ-1:0] pick
);

   // Two's-complement trick isolates the least significant set bit.
   assign pick = vec & (~vec + 4'd1);

endmodule

// File: rtl/arb_4_rr_lock.sv
// Registered round-robin arbiter for four requesters. A grant is held until the owner
// drops its request or MAX_HOLD cycles elapse, then handed off with no idle cycle.
module arb_4_rr_lock
   import arb_4_rr_lock_pkg::*;
#(
   parameter int MAX_HOLD = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [1:0]         grant_id
);

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t             state_reg, state_next;
   logic [1:0]         ptr_reg, ptr_next;
   logic [3:0]         hold_cnt_reg, hold_cnt_next;
   logic [NUM_REQ-1:0] grant_reg, grant_next;
   logic [1:0]         grant_id_reg, grant_id_next;
   logic               grant_valid_reg, grant_valid_next;

   logic [NUM_REQ-1:0] pick_in  [2];
   logic [NUM_REQ-1:0] pick_out [2];
   logic [NUM_REQ-1:0] winner_oh;
   logic [1:0]         winner_id;
   logic               owner_release;

   // Slot 0 sees only requesters above the last winner; slot 1 is the wrap-around fallback.
   assign pick_in[0] = req & mask_above(ptr_reg);
   assign pick_in[1] = req;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pick
         arb_4_lsb_pick u_pick (
            .vec  (pick_in[gi]),
            .pick (pick_out[gi])
         );
      end
   endgenerate

   assign winner_oh     = (|pick_in[0]) ? pick_out[0] : pick_out[1];
   assign winner_id     = onehot_to_idx(winner_oh);
   assign owner_release = !req[grant_id_reg] || (hold_cnt_reg == HOLD_LAST);

   always_comb begin
      state_next       = state_reg;
      ptr_next         = ptr_reg;
      hold_cnt_next    = hold_cnt_reg;
      grant_next       = grant_reg;
      grant_id_next    = grant_id_reg;
      grant_valid_next = grant_valid_reg;

      case (state_reg)
         IDLE: begin
            if (req != '0) begin
               state_next       = OWNED;
               grant_next       = winner_oh;
               grant_id_next    = winner_id;
               grant_valid_next = 1'b1;
               ptr_next         = winner_id;
               hold_cnt_next    = '0;
            end
         end
         OWNED: begin
            if (!owner_release) begin
               hold_cnt_next = hold_cnt_reg + 4'd1;
            end else if (req == '0) begin
               state_next       = IDLE;
               grant_next       = '0;
               grant_id_next    = '0;
               grant_valid_next = 1'b0;
               hold_cnt_next    = '0;
            end else begin
               // The outgoing owner equals ptr, so it naturally drops to lowest priority.
               grant_next       = winner_oh;
               grant_id_next    = winner_id;
               grant_valid_next = 1'b1;
               ptr_next         = winner_id;
               hold_cnt_next    = '0;
            end
         end
         default: begin
            state_next       = IDLE;
            grant_next       = '0;
            grant_id_next    = '0;
            grant_valid_next = 1'b0;
            hold_cnt_next    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         ptr_reg         <= 2'd3;
         hold_cnt_reg    <= '0;
         grant_reg       <= '0;
         grant_id_reg    <= '0;
         grant_valid_reg <= 1'b0;
      end else begin
         state_reg       <= state_next;
         ptr_reg         <= ptr_next;
         hold_cnt_reg    <= hold_cnt_next;
         grant_reg       <= grant_next;
         grant_id_reg    <= grant_id_next;
         grant_valid_reg <= grant_valid_next;
      end
   end

   assign grant       = grant_reg;
   assign grant_valid = grant_valid_reg;
   assign grant_id    = grant_id_reg;

endmodule
